// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
package alu_pkg;

   localparam int DATA_W = 4;
   localparam int REG_N  = 4;
   localparam int ADDR_W = $clog2(REG_N);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_NOT = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_e;

   // Codes above NOT A (101..111) have no ALU meaning and are rejected.
   function automatic logic isOpLegal(input logic [2:0] op);
      return (op <= OP_NOT);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// Four-entry register file: two combinational read ports, one clocked write
// port. Every entry is writable; there is no hardwired zero register.
module alu_regfile
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata
);

   logic [DATA_W-1:0] r_mem [REG_N];

   // Storage array: cleared on reset, one entry written per enabled edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = r_mem[i_raddr1];
   assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/alu_seq.sv
// Three-state instruction sequencer around an external combinational ALU.
// An accepted instruction latches its operands (IDLE), lets the ALU settle
// for one cycle and captures its output (EXEC), then presents and commits
// the result to the register file (WB).
module alu_seq
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [ADDR_W-1:0] instr_rd,
   input  logic [ADDR_W-1:0] instr_rs1,
   input  logic [ADDR_W-1:0] instr_rs2,
   input  logic              instr_imm_en,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [2:0]        ALU_Sel,
   input  logic [DATA_W-1:0] ALU_Out,
   output logic              wb_valid,
   output logic [ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              zero,
   output logic              err
);

   state_e            r_state;
   state_e            w_nextState;
   logic              w_ready;
   logic              w_accept;
   logic              w_wbValid;
   logic              w_err;
   logic              w_we;
   logic              w_capture;
   logic [DATA_W-1:0] w_rdata1;
   logic [DATA_W-1:0] w_rdata2;

   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [2:0]        r_sel;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_result;
   logic [ADDR_W-1:0] r_wbRd;
   logic              r_zero;

   alu_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .i_raddr1 (instr_rs1),
      .i_raddr2 (instr_rs2),
      .o_rdata1 (w_rdata1),
      .o_rdata2 (w_rdata2),
      .i_we     (w_we),
      .i_waddr  (r_wbRd),
      .i_wdata  (r_result)
   );

   // State register; reset aborts any in-flight instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and per-state strobes; an illegal op skips WB and flags err.
   always_comb begin
      w_nextState = r_state;
      w_ready     = 1'b0;
      w_wbValid   = 1'b0;
      w_err       = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (instr_valid) begin
               w_nextState = S_EXEC;
            end
         end
         S_EXEC: begin
            if (isOpLegal(r_sel)) begin
               w_nextState = S_WB;
            end else begin
               w_err       = 1'b1;
               w_nextState = S_IDLE;
            end
         end
         S_WB: begin
            w_wbValid   = 1'b1;
            w_we        = 1'b1;
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   assign w_accept  = instr_valid & w_ready;
   assign w_capture = (r_state == S_EXEC) && isOpLegal(r_sel);

   // Operand latch: sources are read at acceptance and then held steady for
   // the ALU until the next instruction is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_sel <= '0;
         r_rd  <= '0;
      end else if (w_accept) begin
         r_a   <= w_rdata1;
         r_b   <= instr_imm_en ? instr_imm : w_rdata2;
         r_sel <= instr_op;
         r_rd  <= instr_rd;
      end
   end

   // Result capture at the end of EXEC; wb_rd keeps its own copy so it does
   // not follow the next instruction's destination outside WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
         r_wbRd   <= '0;
      end else if (w_capture) begin
         r_result <= ALU_Out;
         r_wbRd   <= r_rd;
      end
   end

   // Zero flag tracks the value committed to the register file.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero <= 1'b0;
      end else if (w_we) begin
         r_zero <= (r_result == '0);
      end
   end

   assign instr_ready = w_ready;
   assign A           = r_a;
   assign B           = r_b;
   assign ALU_Sel     = r_sel;
   assign wb_valid    = w_wbValid;
   assign wb_rd       = r_wbRd;
   assign wb_data     = r_result;
   assign zero        = r_zero;
   assign err         = w_err;

endmodule
